// File: rtl/lr_serializer.sv
// Parallel-in/serial-out feeder for lrshifter: first bit one cycle after an accepted load, WIDTH bits per word.
// Optional LR_SERIALIZER_PARITY_EN appends an even-parity bit; ready reopens on the last bit for gapless words.
module lr_serializer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             direction,
  output logic             ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last
);

`ifdef LR_SERIALIZER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(FRAME);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [FRAME-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             last_bit;
  logic             accept;
  logic [FRAME-1:0] frame_msb;
  logic [FRAME-1:0] frame_lsb;

  // Parity sits at the tail end of the frame so it leaves after the data in either direction.
`ifdef LR_SERIALIZER_PARITY_EN
  assign frame_msb = {din, ^din};
  assign frame_lsb = {^din, din};
`else
  assign frame_msb = din;
  assign frame_lsb = din;
`endif

  assign last_bit   = (state_q == SHIFT) && (cnt_q == '0);
  assign ready      = (state_q == IDLE) || last_bit;
  assign sout_valid = (state_q == SHIFT);
  assign sout_last  = last_bit;
  assign sout       = sout_valid & (dir_q ? sr_q[0] : sr_q[FRAME-1]);
  assign accept     = load & ready;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    if (state_q == SHIFT) begin
      sr_d = dir_q ? (sr_q >> 1) : (sr_q << 1);
      if (last_bit) begin
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
    if (accept) begin
      state_d = SHIFT;
      sr_d    = direction ? frame_lsb : frame_msb;
      cnt_d   = CW'(FRAME - 1);
      dir_d   = direction;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

endmodule

// File: doc/lr_serializer.md
# lr_serializer

Parallel-in, serial-out transmitter that feeds the serial `d` input of the 16-bit left/right shift register (`lrshifter`). It accepts a parallel word and emits it one bit per clock, MSB-first or LSB-first, so the receiving shifter reassembles the original word with the matching `direction`. A load/ready handshake with single-cycle turnaround allows gapless back-to-back words.

## Interface
- `WIDTH`, default 16: data word width in bits; minimum 2.
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high reset.
- `load` input 1: request to accept `din`; only takes effect when `ready` is 1.
- `din` input WIDTH: parallel word, sampled on an accepted `load`.
- `direction` input 1: sampled on an accepted `load`.
  - 0: MSB first, pairs with left-shifting receiver.
  - 1: LSB first, pairs with right-shifting receiver.
- `ready` output 1: block can accept `load` this cycle.
- `sout` output 1: serial data bit, drives receiver `d`.
- `sout_valid` output 1: `sout` carries a valid bit this cycle.
- `sout_last` output 1: high on the final serial bit of a word.

## Operation
- States: IDLE, SHIFT.
- Accept condition: `load & ready`.
  - Latches `din` into the shift register.
  - Latches `direction`.
  - Loads the bit counter with FRAME-1.
  - FRAME = WIDTH, or WIDTH+1 with parity (see Configuration).
- IDLE:
  - `ready`=1, `sout_valid`=0, `sout`=0, `sout_last`=0.
  - An accepted load moves to SHIFT.
- SHIFT:
  - Each cycle, `sout` = current head bit: MSB of the register for direction 0, LSB for direction 1.
  - `sout_valid`=1.
  - The register shifts toward the head by one each cycle; the vacated end fills with 0.
  - The counter decrements each cycle.
- Last bit (counter==0):
  - `sout_last`=1 and `ready`=1.
  - If `load` is high in this cycle, the new word is accepted and SHIFT continues with its first bit next cycle.
  - Otherwise, return to IDLE.
- `load` while `ready`=0 is ignored; no queuing.
- `din` and `direction` changes outside an accepted load have no effect on a word in flight.
- `ready` is combinational from state and counter only, never from `load`.

## Timing
- Reset values:
  - State = IDLE, counter = 0, shift register = 0.
  - `ready`=1, `sout`=0, `sout_valid`=0, `sout_last`=0.
- Latency: load accepted at edge N → first bit on `sout` in cycle N+1 → last bit in cycle N+FRAME.
- Throughput: one word per FRAME cycles with no idle gap when `load` is held at each `sout_last` cycle.
- All outputs are registered, or decoded from registered state with no input-to-output path except none. `ready` has no dependence on `load`.
- Reset asserted mid-word:
  - Next edge forces the reset values.
  - Remaining bits are discarded.
  - `sout_valid` drops in the following cycle.
- Reset and `load` in the same cycle: reset wins; the load is dropped.

## Configuration
- `LR_SERIALIZER_PARITY_EN`
  - Defined:
    - FRAME = WIDTH+1.
    - After the last data bit, one extra bit is sent: even parity, the XOR of all WIDTH bits of the latched `din`.
    - Parity is computed at load time.
    - `sout_last` marks the parity bit, not the last data bit.
  - Undefined:
    - FRAME = WIDTH.
    - No parity logic is synthesized.
    - `sout_last` marks the last data bit.

## Test plan
- MSB-first: reset 2 cycles, then `load`=1, `din`=16'hA5C3, `direction`=0 for one cycle.
  - `sout` over cycles 1–16: 1010010111000011.
  - `sout_valid`=1 for exactly 16 cycles; `sout_last` only on cycle 16.
  - A `lrshifter` with `direction`=0 driven by `sout` ends holding 16'hA5C3.
- LSB-first: `din`=16'hA5C3, `direction`=1.
  - `sout` = 1100001110100101.
  - A right-shifting `lrshifter` ends holding 16'hA5C3.
- Ignored load: after the first load, pulse `load` with `din`=16'hFFFF in cycle 5.
  - Output stream is unchanged.
  - `ready` stays 0 until the `sout_last` cycle.
- Back-to-back: hold `load`=1 with 16'h0001 then 16'h8000, `direction`=0.
  - 32 contiguous valid bits, no gap: 15 zeros, 1, 1, 15 zeros.
- Reset mid-word: assert `reset` in cycle 7 of a word.
  - Next cycle all outputs are at reset values and `ready`=1.
  - A new load sends its full word correctly.
- Parity (with `LR_SERIALIZER_PARITY_EN`):
  - `din`=16'h0007 → 17 bits, final bit 1, `sout_last` on bit 17.
  - `din`=16'h0003 → final bit 0.
